// File: rtl/rpn_sequencer.sv
// RPN token front-end for the stack ALU: buffers postfix tokens, issues one ALU opcode
// per cycle, tracks stack depth locally and reports each expression's result or error.
module rpn_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int STACK_SIZE = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tok_valid_i,
  output logic                  tok_ready_o,
  input  logic [1:0]            tok_kind_i,
  input  logic [DATA_WIDTH-1:0] tok_value_i,
  output logic [2:0]            alu_opcode_o,
  output logic [DATA_WIDTH-1:0] alu_data_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_overflow_i,
  output logic                  res_valid_o,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_error_o,
  output logic                  busy_o
);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DPW = $clog2(STACK_SIZE + 1);
  localparam int TW  = DATA_WIDTH + 2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  typedef enum logic [2:0] {S_RUN, S_WAIT1, S_WAIT2, S_FLUSH, S_DRAIN} state_t;

  // ---------------- token FIFO ----------------
  logic [TW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [1:0]            head_kind;
  logic [DATA_WIDTH-1:0] head_val;

  assign fifo_full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (cnt_q == '0);
  assign tok_ready_o = !fifo_full;
  assign push        = tok_valid_i && tok_ready_o;
  assign head_kind   = mem_q[rd_ptr_q][TW-1 -: 2];
  assign head_val    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {tok_kind_i, tok_value_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // ---------------- sequencer FSM ----------------
  state_t                state_q, state_d;
  logic [DPW-1:0]        depth_q, depth_d;
  logic                  err_q, err_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  re_q, re_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      depth_q <= '0;
      err_q   <= 1'b0;
      op_q    <= OP_NOP;
      data_q  <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    // DRAIN pops only unwind the ALU stack, so their overflow is meaningless
    err_d   = err_q | (alu_overflow_i && (state_q != S_DRAIN));
    op_d    = OP_NOP;
    data_d  = data_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    re_d    = re_q;
    pop     = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_kind)
            K_OPND: begin
              if (depth_q < DPW'(STACK_SIZE)) begin
                op_d    = OP_PUSH;
                data_d  = head_val;
                depth_d = depth_q + DPW'(1);
              end else begin
                err_d   = 1'b1;
                state_d = S_FLUSH;
              end
            end
            K_ADD, K_MUL: begin
              if (depth_q >= DPW'(2)) begin
                op_d    = (head_kind == K_ADD) ? OP_ADD : OP_MUL;
                depth_d = depth_q - DPW'(1);
              end else begin
                err_d   = 1'b1;
                state_d = S_FLUSH;
              end
            end
            default: begin
              if (depth_q == DPW'(1)) begin
                op_d    = OP_POP;
                depth_d = '0;
                state_d = S_WAIT1;
              end else begin
                err_d   = 1'b1;
                state_d = S_DRAIN;
              end
            end
          endcase
        end
      end
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: begin
        rv_d    = 1'b1;
        re_d    = err_d;
        rd_d    = err_d ? '0 : alu_result_i;
        err_d   = 1'b0;
        state_d = S_RUN;
      end
      S_FLUSH: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_kind == K_END) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (depth_q != '0) begin
          op_d    = OP_POP;
          depth_d = depth_q - DPW'(1);
        end else begin
          rv_d    = 1'b1;
          re_d    = 1'b1;
          rd_d    = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign alu_opcode_o = op_q;
  assign alu_data_o   = data_q;
  assign res_valid_o  = rv_q;
  assign res_data_o   = rd_q;
  assign res_error_o  = re_q;
  assign busy_o       = !((state_q == S_RUN) && fifo_empty);

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: a behavioural stack ALU plus an expression-level RPN model
// feeding expected opcode/result queues, checked every cycle, with directed literal checks.
module tb_rpn_sequencer;
  localparam int DW = 8;
  localparam int FD = 8;
  localparam int SS = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [1:0]    tok_kind = 2'b00;
  logic [DW-1:0] tok_value = '0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_data;
  logic [DW-1:0] alu_result;
  logic          alu_overflow;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_error;
  logic          busy;

  always #5 clk = ~clk;

  rpn_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .STACK_SIZE(SS)) dut (
    .clk_i(clk), .rst_i(rst),
    .tok_valid_i(tok_valid), .tok_ready_o(tok_ready),
    .tok_kind_i(tok_kind), .tok_value_i(tok_value),
    .alu_opcode_o(alu_opcode), .alu_data_o(alu_data),
    .alu_result_i(alu_result), .alu_overflow_i(alu_overflow),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_error_o(res_error),
    .busy_o(busy)
  );

  // ---------------- behavioural stack ALU ----------------
  logic [DW-1:0] astk [SS];
  int            asp;
  logic [DW-1:0] alu_res_q;
  logic          ovf_q;
  bit            ovf_arm = 1'b0;

  assign alu_result   = alu_res_q;
  assign alu_overflow = ovf_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      asp       <= 0;
      alu_res_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= ovf_arm && (alu_opcode == 3'b100 || alu_opcode == 3'b101);
      case (alu_opcode)
        3'b110: if (asp < SS) begin astk[asp] <= alu_data; asp <= asp + 1; end
        3'b100: if (asp >= 2) begin astk[asp-2] <= astk[asp-2] + astk[asp-1]; asp <= asp - 1; end
        3'b101: if (asp >= 2) begin astk[asp-2] <= astk[asp-2] * astk[asp-1]; asp <= asp - 1; end
        3'b111: if (asp > 0) begin alu_res_q <= astk[asp-1]; asp <= asp - 1; end
        default: ;
      endcase
    end
  end

  // ---------------- expression-level model ----------------
  typedef struct { logic [2:0] op; logic [DW-1:0] data; } op_t;
  typedef struct { logic err; logic [DW-1:0] data; } res_t;

  op_t           exp_op [$];
  res_t          exp_res [$];
  logic [DW-1:0] m_stk [$];
  bit            m_flush = 1'b0;
  bit            m_ovf = 1'b0;

  function automatic void push_op(logic [2:0] o, logic [DW-1:0] d);
    op_t e;
    e.op = o; e.data = d;
    exp_op.push_back(e);
  endfunction

  function automatic void push_res(logic er, logic [DW-1:0] d);
    res_t r;
    r.err = er; r.data = d;
    exp_res.push_back(r);
  endfunction

  function automatic void m_drain();
    int n = m_stk.size();
    for (int i = 0; i < n; i++) push_op(3'b111, '0);
    m_stk.delete();
    push_res(1'b1, '0);
    m_flush = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_tok(logic [1:0] k, logic [DW-1:0] v);
    logic [DW-1:0] a, b, r;
    if (m_flush) begin
      if (k == 2'b11) m_drain();
      return;
    end
    case (k)
      2'b00: begin
        if (m_stk.size() < SS) begin push_op(3'b110, v); m_stk.push_back(v); end
        else m_flush = 1'b1;
      end
      2'b01, 2'b10: begin
        if (m_stk.size() >= 2) begin
          a = m_stk.pop_back();
          b = m_stk.pop_back();
          r = (k == 2'b01) ? b + a : b * a;
          m_stk.push_back(r);
          push_op((k == 2'b01) ? 3'b100 : 3'b101, '0);
        end else m_flush = 1'b1;
      end
      default: begin
        if (m_stk.size() == 1) begin
          push_op(3'b111, '0);
          if (m_ovf) push_res(1'b1, '0);
          else       push_res(1'b0, m_stk[0]);
          m_stk.delete();
          m_ovf = 1'b0;
        end else m_drain();
      end
    endcase
  endfunction

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int op_cyc [$];
  int acc_q [$];
  int res_cyc = 0;
  int pop_cnt = 0;
  int add_cnt = 0;
  bit saw_nr = 1'b0;
  logic [DW-1:0] last_res_data;
  logic          last_res_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (tok_valid && !tok_ready) saw_nr = 1'b1;

  // per-cycle compare against the model queues
  op_t  ce;
  res_t cr;
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_opcode != 3'b000) begin
        op_cyc.push_back(cyc);
        if (alu_opcode == 3'b111) pop_cnt++;
        if (alu_opcode == 3'b100) add_cnt++;
        tests++;
        if (exp_op.size() == 0) begin
          fails++;
          $display("FAIL op_unexpected: got op=%b data=%0d, required no op", alu_opcode, alu_data);
        end else begin
          ce = exp_op.pop_front();
          if (alu_opcode !== ce.op || (ce.op == 3'b110 && alu_data !== ce.data)) begin
            fails++;
            $display("FAIL op_stream: got op=%b data=%0d, required op=%b data=%0d",
                     alu_opcode, alu_data, ce.op, ce.data);
          end
        end
      end
      if (res_valid) begin
        res_cyc = cyc;
        last_res_data = res_data;
        last_res_err  = res_error;
        tests++;
        if (exp_res.size() == 0) begin
          fails++;
          $display("FAIL res_unexpected: got err=%0d data=%0d", res_error, res_data);
        end else begin
          cr = exp_res.pop_front();
          if (res_error !== cr.err || res_data !== cr.data) begin
            fails++;
            $display("FAIL result: got err=%0d data=%0d, required err=%0d data=%0d",
                     res_error, res_data, cr.err, cr.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the token was accepted
  task automatic send(input logic [1:0] k, input logic [DW-1:0] v, input bit mdl);
    int n = 0;
    if (mdl) model_tok(k, v);
    tok_valid = 1'b1; tok_kind = k; tok_value = v;
    while (!tok_ready && n < 500) begin @(negedge clk); n++; end
    if (!tok_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: tok_ready stuck low, required high");
    end
    @(negedge clk);
    acc_q.push_back(cyc);
  endtask

  task automatic wait_done();
    int n = 0;
    tok_valid = 1'b0;
    while ((exp_op.size() != 0 || exp_res.size() != 0 || busy) && n < 1000) begin
      @(negedge clk); n++;
    end
    tests++;
    if (n >= 1000) begin
      fails++;
      $display("FAIL wait_timeout: ops left %0d results left %0d busy %0d, required all 0",
               exp_op.size(), exp_res.size(), busy);
    end
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_opcode"}, int'(alu_opcode), 0);
    chk({tag, "_alu_data"}, int'(alu_data), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_data"}, int'(res_data), 0);
    chk({tag, "_res_error"}, int'(res_error), 0);
    chk({tag, "_tok_ready"}, int'(tok_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_checks("rst0");
    rst = 1'b0;
    @(negedge clk);

    // simple add: 3 4 + end
    op_cyc.delete(); acc_q.delete();
    send(2'b00, 8'd3, 1); send(2'b00, 8'd4, 1); send(2'b01, 0, 1); send(2'b11, 0, 1);
    wait_done();
    chk("add_nops", op_cyc.size(), 4);
    if (op_cyc.size() == 4) begin
      chk("add_tok_lat", op_cyc[0] - acc_q[0], 1);
      chk("add_b2b", op_cyc[3] - op_cyc[0], 3);
      chk("add_res_lat", res_cyc - op_cyc[3], 2);
    end
    chk("add_res", int'(last_res_data), 7);
    chk("add_err", int'(last_res_err), 0);

    // mixed: 5 6 * 2 + end = 32
    send(2'b00, 8'd5, 1); send(2'b00, 8'd6, 1); send(2'b10, 0, 1);
    send(2'b00, 8'd2, 1); send(2'b01, 0, 1); send(2'b11, 0, 1);
    wait_done();
    chk("mix_res", int'(last_res_data), 32);
    chk("mix_err", int'(last_res_err), 0);
    chk("mix_idle", int'(busy), 0);

    // underflow: + end on empty stack
    add_cnt = 0;
    send(2'b01, 0, 1); send(2'b11, 0, 1);
    wait_done();
    chk("uf_no_add", add_cnt, 0);
    chk("uf_err", int'(last_res_err), 1);
    chk("uf_data", int'(last_res_data), 0);

    // leftover operands: 1 2 end, then 9 end
    pop_cnt = 0;
    send(2'b00, 8'd1, 1); send(2'b00, 8'd2, 1); send(2'b11, 0, 1);
    wait_done();
    chk("left_pops", pop_cnt, 2);
    chk("left_err", int'(last_res_err), 1);
    send(2'b00, 8'd9, 1); send(2'b11, 0, 1);
    wait_done();
    chk("after_left_res", int'(last_res_data), 9);
    chk("after_left_err", int'(last_res_err), 0);

    // overflow: ALU flags the add of 100 100 + end
    ovf_arm = 1'b1; m_ovf = 1'b1;
    send(2'b00, 8'd100, 1); send(2'b00, 8'd100, 1); send(2'b01, 0, 1); send(2'b11, 0, 1);
    wait_done();
    ovf_arm = 1'b0;
    chk("ovf_err", int'(last_res_err), 1);
    chk("ovf_data", int'(last_res_data), 0);
    send(2'b00, 8'd100, 1); send(2'b00, 8'd27, 1); send(2'b01, 0, 1); send(2'b11, 0, 1);
    wait_done();
    chk("post_ovf_res", int'(last_res_data), 127);
    chk("post_ovf_err", int'(last_res_err), 0);

    // stack capacity: 65 operands overflow the depth check; then bare end; then 2 3 * end
    pop_cnt = 0;
    for (int i = 0; i < SS + 1; i++) send(2'b00, DW'(i), 1);
    send(2'b11, 0, 1);
    wait_done();
    chk("full_pops", pop_cnt, SS);
    chk("full_err", int'(last_res_err), 1);
    send(2'b11, 0, 1);
    wait_done();
    chk("bare_end_err", int'(last_res_err), 1);
    send(2'b00, 8'd2, 1); send(2'b00, 8'd3, 1); send(2'b10, 0, 1); send(2'b11, 0, 1);
    wait_done();
    chk("mul_res", int'(last_res_data), 6);

    // backpressure: 1+2+3+4+5 arriving while 20 leftovers drain
    saw_nr = 1'b0;
    for (int i = 0; i < 20; i++) send(2'b00, 8'd1, 1);
    send(2'b11, 0, 1);
    send(2'b00, 8'd1, 1); send(2'b00, 8'd2, 1); send(2'b01, 0, 1);
    send(2'b00, 8'd3, 1); send(2'b01, 0, 1); send(2'b00, 8'd4, 1); send(2'b01, 0, 1);
    send(2'b00, 8'd5, 1); send(2'b01, 0, 1); send(2'b11, 0, 1);
    wait_done();
    chk("bp_ready_dropped", int'(saw_nr), 1);
    chk("bp_res", int'(last_res_data), 15);
    chk("bp_err", int'(last_res_err), 0);

    // reset mid-drain with a full FIFO
    for (int i = 0; i < 20; i++) send(2'b00, 8'd7, 1);
    send(2'b11, 0, 1);
    for (int i = 0; i < FD; i++) send(2'b00, 8'd3, 0);
    tok_valid = 1'b0;
    chk("fifo_full_ready", int'(tok_ready), 0);
    chk("fifo_full_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1 reset_checks("rst_mid");
    exp_op.delete(); exp_res.delete(); m_stk.delete();
    m_flush = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(2'b00, 8'd9, 1); send(2'b11, 0, 1);
    wait_done();
    chk("post_rst_res", int'(last_res_data), 9);
    chk("post_rst_err", int'(last_res_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
